// File: rtl/inst_fifo.sv
// inst_fifo: instruction buffer between fetch and the backend decoder.
//
// A DEPTH-entry circular queue. Fetch pushes up to two instructions per
// cycle (valid lanes compacted in lane order) together with their
// branch-prediction and exception metadata. The two oldest entries are
// presented to the decoder; lane 0 is the oldest. The decoder pops with
// send_inst_en. flush / bpu_flush empty the queue on the next edge and
// take priority over a push or pop in the same cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   flush, bpu_flush            : discard all entries
//   fetch_*                     : per-lane push data, fetch_valid per lane
//   fetch_ready                 : at least two free entries (pre-pop count)
//   send_inst_en                : decoder pops lane 0 / lane 1
//   pc, inst, pre_*, is_exception, exception_cause : head-entry fields
//   out_valid                   : per-lane entry valid
//   pause_buffer                : buffer empty
//
// Optional feature (macro INST_FIFO_PERF_EN): adds saturating 32-bit
// counters perf_full_cycles (cycles with fetch_ready=0) and
// perf_empty_cycles (cycles with pause_buffer=1); not cleared by flush.
//
// All outputs are driven from registers only.

module inst_fifo #(
  parameter int DEPTH         = 16,
  parameter int DECODER_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                bpu_flush,
  input  logic [DECODER_WIDTH-1:0]            fetch_valid,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_pc,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_inst,
  input  logic [DECODER_WIDTH-1:0]            fetch_pre_is_branch,
  input  logic [DECODER_WIDTH-1:0]            fetch_pre_is_branch_taken,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_pre_branch_addr,
  input  logic [DECODER_WIDTH-1:0][5:0]       fetch_is_exception,
  input  logic [DECODER_WIDTH-1:0][5:0][6:0]  fetch_exception_cause,
  output logic                                fetch_ready,
  input  logic [DECODER_WIDTH-1:0]            send_inst_en,
  output logic [DECODER_WIDTH-1:0][31:0]      pc,
  output logic [DECODER_WIDTH-1:0][31:0]      inst,
  output logic [DECODER_WIDTH-1:0]            pre_is_branch,
  output logic [DECODER_WIDTH-1:0]            pre_is_branch_taken,
  output logic [DECODER_WIDTH-1:0][31:0]      pre_branch_addr,
  output logic [DECODER_WIDTH-1:0][5:0]       is_exception,
  output logic [DECODER_WIDTH-1:0][5:0][6:0]  exception_cause,
  output logic [DECODER_WIDTH-1:0]            out_valid,
  output logic                                pause_buffer
`ifdef INST_FIFO_PERF_EN
  ,
  output logic [31:0]                         perf_full_cycles,
  output logic [31:0]                         perf_empty_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // 146-bit storage entry
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             br;
    logic             taken;
    logic [31:0]      target;
    logic [5:0]       exc;
    logic [5:0][6:0]  cause;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [AW-1:0]   wr_ptr_p1;
  logic [AW-1:0]   rd_ptr_p1;
  logic [1:0]      push_n;
  logic [1:0]      pop_n;
  entry_t          in_e   [2];
  entry_t          lane_e [2];

  assign wr_ptr_p1 = wr_ptr_q + AW'(1);
  assign rd_ptr_p1 = rd_ptr_q + AW'(1);

  // Status from registered count only
  assign fetch_ready  = (CW'(DEPTH) - count_q) >= CW'(2);
  assign out_valid[0] = count_q >= CW'(1);
  assign out_valid[1] = count_q >= CW'(2);
  assign pause_buffer = (count_q == '0);

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      in_e[i].pc     = fetch_pc[i];
      in_e[i].inst   = fetch_inst[i];
      in_e[i].br     = fetch_pre_is_branch[i];
      in_e[i].taken  = fetch_pre_is_branch_taken[i];
      in_e[i].target = fetch_pre_branch_addr[i];
      in_e[i].exc    = fetch_is_exception[i];
      in_e[i].cause  = fetch_exception_cause[i];
    end
  end

  // Head lanes; invalid lanes are forced to zero
  always_comb begin
    lane_e[0] = out_valid[0] ? mem_q[rd_ptr_q]  : '0;
    lane_e[1] = out_valid[1] ? mem_q[rd_ptr_p1] : '0;
    for (int unsigned i = 0; i < 2; i++) begin
      pc[i]                  = lane_e[i].pc;
      inst[i]                = lane_e[i].inst;
      pre_is_branch[i]       = lane_e[i].br;
      pre_is_branch_taken[i] = lane_e[i].taken;
      pre_branch_addr[i]     = lane_e[i].target;
      is_exception[i]        = lane_e[i].exc;
      exception_cause[i]     = lane_e[i].cause;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    push_n   = '0;
    pop_n    = '0;
    if (flush || bpu_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch_ready) begin
        // Valid lanes are compacted: the first valid lane lands at wr_ptr
        unique case (fetch_valid)
          2'b01: begin
            mem_d[wr_ptr_q] = in_e[0];
            push_n          = 2'd1;
          end
          2'b10: begin
            mem_d[wr_ptr_q] = in_e[1];
            push_n          = 2'd1;
          end
          2'b11: begin
            mem_d[wr_ptr_q]  = in_e[0];
            mem_d[wr_ptr_p1] = in_e[1];
            push_n           = 2'd2;
          end
          default: push_n = '0;
        endcase
      end
      // Lane 1 pop without lane 0 is illegal and pops nothing
      if (send_inst_en[0] && out_valid[0]) begin
        pop_n = (send_inst_en[1] && out_valid[1]) ? 2'd2 : 2'd1;
      end
      wr_ptr_d = wr_ptr_q + AW'(push_n);
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      count_d  = count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: unread slots are masked by out_valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef INST_FIFO_PERF_EN
  logic [31:0] perf_full_q,  perf_full_d;
  logic [31:0] perf_empty_q, perf_empty_d;

  always_comb begin
    perf_full_d  = perf_full_q;
    perf_empty_d = perf_empty_q;
    if (!fetch_ready && (perf_full_q != '1)) perf_full_d = perf_full_q + 32'd1;
    if (pause_buffer && (perf_empty_q != '1)) perf_empty_d = perf_empty_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_full_q  <= perf_full_d;
      perf_empty_q <= perf_empty_d;
    end
  end

  assign perf_full_cycles  = perf_full_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

  illegal_lane1_pop: assert property (
    @(posedge clk) disable iff (!rst) send_inst_en != 2'b10
  );

endmodule
